// File: rtl/mtm_alu_result_deserializer.sv
// Receive side of the ALU result serial link: rebuilds C/CTL responses
// from 11-bit packets (start, type, 8 data bits MSB first, stop).
module mtm_alu_result_deserializer #(
    parameter int DATA_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sin,
    output logic [8*DATA_BYTES-1:0] c_out,
    output logic [7:0]              ctl_out,
    output logic                    valid,
    output logic                    err_rsp,
    output logic                    frame_err
);

    localparam int BCW = $clog2(DATA_BYTES + 1);
    localparam int DW  = 8 * DATA_BYTES;

    localparam logic [BCW-1:0] LP_FULL = BCW'(DATA_BYTES);
    localparam logic [BCW-1:0] LP_ONE  = BCW'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PKT,
        ST_DATA,
        ST_STOP,
        ST_GAP,
        ST_RESYNC
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic           r_type;
    logic [2:0]     r_bit_cnt;
    logic [BCW-1:0] r_byte_cnt;
    logic [7:0]     r_byte_sr;
    logic [DW-1:0]  r_data;

    logic [DW-1:0]  r_c_out;
    logic [7:0]     r_ctl_out;
    logic           r_valid;
    logic           r_err_rsp;
    logic           r_frame_err;

    logic           w_cnt_zero;
    logic           w_cnt_full;
    logic           w_data_ok;
    logic           w_data_xs;
    logic           w_ctl_norm;
    logic           w_ctl_err;

    logic           w_store;
    logic           w_drop;
    logic           w_done_norm;
    logic           w_done_err;
    logic           w_ferr;
    logic           w_clr;

    assign w_cnt_zero = (r_byte_cnt == '0);
    assign w_cnt_full = (r_byte_cnt == LP_FULL);

    // Stop-bit outcomes; each one already requires a good stop bit
    assign w_data_ok  = sin & ~r_type & ~w_cnt_full;
    assign w_data_xs  = sin & ~r_type &  w_cnt_full;
    assign w_ctl_norm = sin &  r_type &  w_cnt_full;
    assign w_ctl_err  = sin &  r_type &  w_cnt_zero & ~w_cnt_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_store     = 1'b0;
        w_drop      = 1'b0;
        w_done_norm = 1'b0;
        w_done_err  = 1'b0;
        w_ferr      = 1'b0;
        unique case (r_state)
            ST_IDLE, ST_GAP: begin
                if (!sin) begin
                    w_state_nxt = ST_PKT;
                end
            end
            ST_PKT: begin
                w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (r_bit_cnt == 3'd7) begin
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                w_state_nxt = ST_IDLE;
                unique case (1'b1)
                    !sin: begin
                        w_ferr      = 1'b1;
                        w_drop      = 1'b1;
                        w_state_nxt = ST_RESYNC;
                    end
                    w_data_ok: begin
                        w_store     = 1'b1;
                        w_state_nxt = ST_GAP;
                    end
                    w_data_xs: begin
                        w_ferr = 1'b1;
                        w_drop = 1'b1;
                    end
                    w_ctl_norm: begin
                        w_done_norm = 1'b1;
                    end
                    w_ctl_err: begin
                        w_done_err = 1'b1;
                    end
                    default: begin
                        w_ferr = 1'b1;
                        w_drop = 1'b1;
                    end
                endcase
            end
            ST_RESYNC: begin
                // a stuck-low line must see a 1 before a start bit counts
                if (sin) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_clr = w_drop | w_done_norm | w_done_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_type     <= 1'b0;
            r_bit_cnt  <= 3'd0;
            r_byte_cnt <= '0;
            r_byte_sr  <= 8'd0;
            r_data     <= '0;
        end else begin
            if (r_state == ST_PKT) begin
                r_type    <= sin;
                r_bit_cnt <= 3'd0;
            end
            if (r_state == ST_DATA) begin
                r_byte_sr <= {r_byte_sr[6:0], sin};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_store) begin
                r_data     <= (r_data << 8) | DW'(r_byte_sr);
                r_byte_cnt <= r_byte_cnt + LP_ONE;
            end
            if (w_clr) begin
                r_data     <= '0;
                r_byte_cnt <= '0;
            end
        end
    end

    // Result registers hold across frame errors until the next valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c_out     <= '0;
            r_ctl_out   <= 8'd0;
            r_valid     <= 1'b0;
            r_err_rsp   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_valid     <= w_done_norm | w_done_err;
            r_frame_err <= w_ferr;
            if (w_done_norm) begin
                r_c_out   <= r_data;
                r_ctl_out <= r_byte_sr;
                r_err_rsp <= 1'b0;
            end
            if (w_done_err) begin
                r_c_out   <= '0;
                r_ctl_out <= r_byte_sr;
                r_err_rsp <= 1'b1;
            end
        end
    end

    assign c_out     = r_c_out;
    assign ctl_out   = r_ctl_out;
    assign valid     = r_valid;
    assign err_rsp   = r_err_rsp;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_mtm_alu_result_deserializer.sv
// Bench for mtm_alu_result_deserializer: vector table, directed
// corner cases and a random packet stream against a packet-level model.
module tb_mtm_alu_result_deserializer;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        sin   = 1'b1;
    logic [31:0] c_out;
    logic [7:0]  ctl_out;
    logic        valid;
    logic        err_rsp;
    logic        frame_err;

    always #5 clk = ~clk;

    mtm_alu_result_deserializer #(.DATA_BYTES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sin       (sin),
        .c_out     (c_out),
        .ctl_out   (ctl_out),
        .valid     (valid),
        .err_rsp   (err_rsp),
        .frame_err (frame_err)
    );

    typedef struct {
        bit         ctl;
        logic [7:0] b;
        bit         stop_ok;
        int         gap;
        int         low;
    } pkt_t;

    typedef struct {
        bit          v;
        bit          f;
        logic [31:0] c;
        logic [7:0]  ctl;
        bit          e;
        int          cyc;
    } ev_t;

    typedef struct {
        int          nd;
        logic [39:0] d;
        bit          has_ctl;
        logic [7:0]  cb;
        bit          xf;
        logic [31:0] xc;
        logic [7:0]  xctl;
        bit          xerr;
    } vec_t;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_err = 0;
    ev_t         obs_q[$];
    int          edge_q[$];
    logic [7:0]  byte_q[$];
    logic [31:0] lv_c = 0;
    logic [7:0]  lv_ctl = 0;
    bit          lv_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && (valid || frame_err)) begin
            obs_q.push_back('{valid, frame_err, c_out, ctl_out, err_rsp, cyc});
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic pkt_t mk(input bit ctl, input logic [7:0] b,
                                input bit ok, input int gap, input int low);
        pkt_t p;
        p.ctl = ctl; p.b = b; p.stop_ok = ok; p.gap = gap; p.low = low;
        return p;
    endfunction

    task automatic send_bit(input logic b);
        @(negedge clk);
        sin = b;
    endtask

    task automatic send_packet(input pkt_t p);
        repeat (p.gap) send_bit(1'b1);
        send_bit(1'b0);
        send_bit(p.ctl);
        for (int i = 7; i >= 0; i--) send_bit(p.b[i]);
        send_bit(p.stop_ok);
        edge_q.push_back(cyc + 1);
        if (!p.stop_ok) begin
            repeat (p.low) send_bit(1'b0);
            send_bit(1'b1);
        end
    endtask

    task automatic drain();
        repeat (3) send_bit(1'b1);
    endtask

    task automatic compare(input ev_t ex[$], input string tag);
        int n;
        chk({tag, "_count"}, obs_q.size(), ex.size());
        n = (obs_q.size() < ex.size()) ? obs_q.size() : ex.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_%0d_valid", tag, i), obs_q[i].v, ex[i].v);
            chk($sformatf("%s_%0d_ferr", tag, i), obs_q[i].f, ex[i].f);
            chk($sformatf("%s_%0d_cycle", tag, i), obs_q[i].cyc, ex[i].cyc);
            chk($sformatf("%s_%0d_c", tag, i), obs_q[i].c, ex[i].c);
            chk($sformatf("%s_%0d_ctl", tag, i), obs_q[i].ctl, ex[i].ctl);
            chk($sformatf("%s_%0d_err", tag, i), obs_q[i].e, ex[i].e);
        end
        obs_q.delete();
        edge_q.delete();
    endtask

    // Packet-level reference: collect data bytes, resolve on CTL or fault
    task automatic run_stream(input pkt_t pq[$], input string tag);
        ev_t ex[$];
        ev_t e;
        foreach (pq[i]) send_packet(pq[i]);
        drain();
        foreach (pq[i]) begin
            e = '{0, 0, lv_c, lv_ctl, lv_err, edge_q[i]};
            if (!pq[i].stop_ok) begin
                e.f = 1; byte_q.delete(); ex.push_back(e);
            end else if (!pq[i].ctl) begin
                if (byte_q.size() < 4) begin
                    byte_q.push_back(pq[i].b);
                end else begin
                    e.f = 1; byte_q.delete(); ex.push_back(e);
                end
            end else if (byte_q.size() == 4) begin
                lv_c = {byte_q[0], byte_q[1], byte_q[2], byte_q[3]};
                lv_ctl = pq[i].b; lv_err = 0;
                e = '{1, 0, lv_c, lv_ctl, lv_err, edge_q[i]};
                byte_q.delete(); ex.push_back(e);
            end else if (byte_q.size() == 0) begin
                lv_c = 0; lv_ctl = pq[i].b; lv_err = 1;
                e = '{1, 0, lv_c, lv_ctl, lv_err, edge_q[i]};
                ex.push_back(e);
            end else begin
                e.f = 1; byte_q.delete(); ex.push_back(e);
            end
        end
        compare(ex, tag);
    endtask

    task automatic add_resp(inout pkt_t pq[$], input logic [31:0] c,
                            input logic [7:0] ctl, input bit rnd_gap);
        for (int j = 3; j >= 0; j--) begin
            pq.push_back(mk(0, c[j*8 +: 8], 1, rnd_gap ? $urandom_range(0, 7) : 0, 0));
        end
        pq.push_back(mk(1, ctl, 1, rnd_gap ? $urandom_range(0, 7) : 0, 0));
    endtask

    initial begin
        vec_t vt[10];
        pkt_t pq[$];
        int   last;
        int   k;

        vt[0] = '{4, 40'h12345678_00, 1, 8'h0E, 0, 32'h12345678, 8'h0E, 0};
        vt[1] = '{0, 40'h0,           1, 8'hC9, 0, 32'h0,        8'hC9, 1};
        vt[2] = '{0, 40'h0,           1, 8'h93, 0, 32'h0,        8'h93, 1};
        vt[3] = '{0, 40'h0,           1, 8'hA5, 0, 32'h0,        8'hA5, 1};
        vt[4] = '{2, 40'h11220000_00, 1, 8'h33, 1, 32'h0,        8'h0,  0};
        vt[5] = '{4, 40'hCAFEF00D_00, 1, 8'h3C, 0, 32'hCAFEF00D, 8'h3C, 0};
        vt[6] = '{5, 40'h01020304_05, 0, 8'h00, 1, 32'h0,        8'h0,  0};
        vt[7] = '{1, 40'h77000000_00, 1, 8'h88, 1, 32'h0,        8'h0,  0};
        vt[8] = '{3, 40'h99AABB00_00, 1, 8'h44, 1, 32'h0,        8'h0,  0};
        vt[9] = '{4, 40'h89ABCDEF_00, 1, 8'h80, 0, 32'h89ABCDEF, 8'h80, 0};

        repeat (3) @(negedge clk);
        chk("rst_c_out", c_out, 0);
        chk("rst_ctl_out", ctl_out, 0);
        chk("rst_valid", valid, 0);
        chk("rst_err_rsp", err_rsp, 0);
        chk("rst_frame_err", frame_err, 0);
        rst_n = 1'b1;
        repeat (2) send_bit(1'b1);

        for (int i = 0; i < 10; i++) begin
            pq.delete();
            for (int j = 0; j < vt[i].nd; j++) begin
                pq.push_back(mk(0, vt[i].d[39-8*j -: 8], 1, 0, 0));
            end
            if (vt[i].has_ctl) pq.push_back(mk(1, vt[i].cb, 1, 0, 0));
            foreach (pq[j]) send_packet(pq[j]);
            drain();
            last = edge_q[edge_q.size()-1];
            chk($sformatf("vec%0d_count", i), obs_q.size(), 1);
            if (obs_q.size() >= 1) begin
                chk($sformatf("vec%0d_valid", i), obs_q[0].v, !vt[i].xf);
                chk($sformatf("vec%0d_ferr", i), obs_q[0].f, vt[i].xf);
                chk($sformatf("vec%0d_cycle", i), obs_q[0].cyc, last);
                chk($sformatf("vec%0d_c", i), obs_q[0].c,
                    vt[i].xf ? lv_c : vt[i].xc);
                chk($sformatf("vec%0d_ctl", i), obs_q[0].ctl,
                    vt[i].xf ? lv_ctl : vt[i].xctl);
                chk($sformatf("vec%0d_err", i), obs_q[0].e,
                    vt[i].xf ? lv_err : vt[i].xerr);
            end
            if (!vt[i].xf) begin
                lv_c = vt[i].xc; lv_ctl = vt[i].xctl; lv_err = vt[i].xerr;
            end
            obs_q.delete();
            edge_q.delete();
        end

        // Bad stop in 2nd data packet, line stuck low, then a clean response
        pq.delete();
        pq.push_back(mk(0, 8'h11, 1, 0, 0));
        pq.push_back(mk(0, 8'h22, 0, 0, 20));
        add_resp(pq, 32'hDEADBEEF, 8'h05, 0);
        run_stream(pq, "framing");

        // Async reset in the middle of the 3rd data byte
        send_packet(mk(0, 8'hA1, 1, 0, 0));
        send_packet(mk(0, 8'hB2, 1, 0, 0));
        send_bit(1'b0); send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        #7;
        rst_n = 1'b0;
        #1;
        chk("midrst_c_out", c_out, 0);
        chk("midrst_ctl_out", ctl_out, 0);
        chk("midrst_valid", valid, 0);
        chk("midrst_err_rsp", err_rsp, 0);
        chk("midrst_frame_err", frame_err, 0);
        chk("midrst_no_event", obs_q.size(), 0);
        sin = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        byte_q.delete(); obs_q.delete(); edge_q.delete();
        lv_c = 0; lv_ctl = 0; lv_err = 0;
        pq.delete();
        add_resp(pq, 32'hA5A5A5A5, 8'h01, 0);
        run_stream(pq, "postrst");

        pq.delete();
        add_resp(pq, 32'hFFFFFFFF, 8'h7F, 0);
        add_resp(pq, 32'h00000000, 8'h00, 0);
        run_stream(pq, "b2b");

        pq.delete();
        add_resp(pq, 32'h0BADF00D, 8'h2A, 1);
        add_resp(pq, 32'h13579BDF, 8'hE1, 1);
        run_stream(pq, "gaps");

        pq.delete();
        for (int r = 0; r < 30; r++) begin
            k = $urandom_range(0, 9);
            if (k <= 5) begin
                add_resp(pq, $urandom, 8'($urandom), 1);
            end else if (k <= 7) begin
                pq.push_back(mk(1, 8'($urandom), 1, $urandom_range(0, 7), 0));
            end else if (k == 8) begin
                pq.push_back(mk($urandom_range(0, 1), 8'($urandom), 1,
                                $urandom_range(0, 7), 0));
            end else begin
                pq.push_back(mk($urandom_range(0, 1), 8'($urandom), 0,
                                $urandom_range(0, 7), $urandom_range(0, 3)));
            end
        end
        run_stream(pq, "rand");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
